// File: rtl/pot_pkg.sv
// Shared command encodings, frame geometry and readback layout for the
// digital potentiometer wiper controller.
package pot_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_SET = 2'b01;
  localparam logic [1:0] CMD_INC = 2'b10;
  localparam logic [1:0] CMD_DEC = 2'b11;

  // Readback word: {busy, frame_err, 6'b0, wiper zero-extended to 8 bits}
  function automatic logic [FRAME_BITS-1:0] rb_frame(input logic       busy,
                                                     input logic       err,
                                                     input logic [7:0] code);
    return {busy, err, 6'b000000, code};
  endfunction

endpackage

// File: rtl/pot_spi_rx.sv
// SPI mode-0 slave front end: pin synchronizers, edge detection, bit counter,
// command shifter and readback shifter.
module pot_spi_rx
  import pot_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  input  logic       i_rb_busy,
  input  logic       i_rb_err,
  input  logic [7:0] i_rb_code,
  output logic       o_miso,
  output logic       o_cmd_valid,
  output logic [1:0] o_cmd,
  output logic [7:0] o_data,
  output logic       o_frame_bad
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic                  r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic                  r_cs_s1, r_cs_s2, r_cs_d;
  logic                  r_mosi_s1, r_mosi_s2;
  logic [CNT_W-1:0]      r_cnt;
  logic [FRAME_BITS-1:0] r_rx_shift;
  logic [FRAME_BITS-1:0] r_tx_shift;
  logic                  r_cmd_valid;
  logic                  r_frame_bad;

  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  // sclk edges only count while the synchronized select is active
  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d & ~r_cs_s2;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d & ~r_cs_s2;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_d    <= 1'b0;
      r_cs_s1     <= 1'b1;
      r_cs_s2     <= 1'b1;
      r_cs_d      <= 1'b1;
      r_mosi_s1   <= 1'b0;
      r_mosi_s2   <= 1'b0;
      r_cnt       <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_cmd_valid <= 1'b0;
      r_frame_bad <= 1'b0;
    end else begin
      r_sclk_s1   <= i_sclk;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_d    <= r_sclk_s2;
      r_cs_s1     <= i_cs_n;
      r_cs_s2     <= r_cs_s1;
      r_cs_d      <= r_cs_s2;
      r_mosi_s1   <= i_mosi;
      r_mosi_s2   <= r_mosi_s1;
      r_cmd_valid <= 1'b0;
      r_frame_bad <= 1'b0;
      if (w_cs_fall) begin
        r_cnt      <= '0;
        r_rx_shift <= '0;
        r_tx_shift <= rb_frame(i_rb_busy, i_rb_err, i_rb_code);
      end else if (w_cs_rise) begin
        if (r_cnt == CNT_FULL) r_cmd_valid <= 1'b1;
        else                   r_frame_bad <= 1'b1;
        r_cnt      <= '0;
        r_tx_shift <= '0;
      end else begin
        if (w_sclk_rise) begin
          r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], r_mosi_s2};
          if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_sclk_fall) r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  // The rx shifter is frozen between cs_n rise and the next fall, so the
  // command fields stay stable while the commit pulse is high.
  assign o_miso      = r_tx_shift[FRAME_BITS-1];
  assign o_cmd       = r_rx_shift[FRAME_BITS-1:FRAME_BITS-2];
  assign o_data      = r_rx_shift[7:0];
  assign o_cmd_valid = r_cmd_valid;
  assign o_frame_bad = r_frame_bad;

endmodule

// File: rtl/pot_wiper_ctrl.sv
// Wiper controller top: holds the target code, applies saturating INC/DEC and
// slews the wiper toward the target by one LSB every RAMP_DIV clocks.
module pot_wiper_ctrl
  import pot_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RAMP_DIV   = 16,
  parameter int RESET_CODE = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] wiper,
  output logic             busy,
  output logic             frame_err
);

  localparam int               DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [WIDTH-1:0] CODE_RST = WIDTH'(RESET_CODE);

  logic [WIDTH-1:0] r_target, r_wiper;
  logic [DIV_W-1:0] r_div;
  logic             r_busy, r_err;

  logic             w_cmd_valid, w_frame_bad;
  logic [1:0]       w_cmd;
  logic [7:0]       w_data;
  logic [WIDTH-1:0] w_operand, w_target_nxt, w_wiper_nxt;
  logic [DIV_W-1:0] w_div_nxt;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[WIDTH] ? {WIDTH{1'b0}} : d[WIDTH-1:0];
  endfunction

  pot_spi_rx u_spi_rx (
    .clk        (clk),
    .rst        (rst),
    .i_sclk     (sclk),
    .i_cs_n     (cs_n),
    .i_mosi     (mosi),
    .i_rb_busy  (r_busy),
    .i_rb_err   (r_err),
    .i_rb_code  (8'(r_wiper)),
    .o_miso     (miso),
    .o_cmd_valid(w_cmd_valid),
    .o_cmd      (w_cmd),
    .o_data     (w_data),
    .o_frame_bad(w_frame_bad)
  );

  assign w_operand = w_data[WIDTH-1:0];

  // Ramp decisions use the registered target, so a same-cycle commit only
  // takes effect on the following step.
  always_comb begin
    w_target_nxt = r_target;
    if (w_cmd_valid) begin
      case (w_cmd)
        CMD_NOP: w_target_nxt = r_target;
        CMD_SET: w_target_nxt = w_operand;
        CMD_INC: w_target_nxt = sat_add(r_target, w_operand);
        CMD_DEC: w_target_nxt = sat_sub(r_target, w_operand);
        default: w_target_nxt = r_target;
      endcase
    end

    w_wiper_nxt = r_wiper;
    w_div_nxt   = '0;
    if (r_wiper != r_target) begin
      if (r_div == DIV_LAST) begin
        w_wiper_nxt = (r_wiper < r_target) ? r_wiper + WIDTH'(1) : r_wiper - WIDTH'(1);
      end else begin
        w_div_nxt = r_div + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_target <= CODE_RST;
      r_wiper  <= CODE_RST;
      r_div    <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_target <= w_target_nxt;
      r_wiper  <= w_wiper_nxt;
      r_div    <= w_div_nxt;
      r_busy   <= (w_wiper_nxt != w_target_nxt);
      if (w_cmd_valid)      r_err <= 1'b0;
      else if (w_frame_bad) r_err <= 1'b1;
    end
  end

  assign wiper     = r_wiper;
  assign busy      = r_busy;
  assign frame_err = r_err;

endmodule

// File: tb/tb_pot_wiper_ctrl.sv
// Directed bench for pot_wiper_ctrl: SPI command frames, ramp timing,
// saturation, malformed frames, readback and reset mid-frame.
module tb_pot_wiper_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, busy, frame_err;
  logic [7:0] wiper;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pot_wiper_ctrl #(.WIDTH(8), .RAMP_DIV(16), .RESET_CODE(128)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .wiper    (wiper),
    .busy     (busy),
    .frame_err(frame_err)
  );

  // Drive one frame of nbits (MSB first) and collect miso before each rise.
  task automatic spi_xfer(input logic [15:0] word, input int nbits, output logic [15:0] rb);
    rb   = '0;
    cs_n = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[15 - (i % 16)];
      #50;
      if (i < 16) rb[15 - i] = miso;
      sclk = 1'b1;
      #50;
      sclk = 1'b0;
    end
    #50;
    cs_n = 1'b1;
    mosi = 1'b0;
  endtask

  // Let a commit land, then follow the ramp until idle, tracking the largest step.
  task automatic wait_settle(input int budget, output int maxstep);
    int prev, diff, n;
    maxstep = 0;
    prev    = int'(wiper);
    n       = 0;
    repeat (8) begin
      @(posedge clk); #1;
      diff = int'(wiper) - prev;
      if (diff < 0) diff = -diff;
      if (diff > maxstep) maxstep = diff;
      prev = int'(wiper);
    end
    while (busy && n < budget) begin
      @(posedge clk); #1;
      diff = int'(wiper) - prev;
      if (diff < 0) diff = -diff;
      if (diff > maxstep) maxstep = diff;
      prev = int'(wiper);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (wiper !== 8'd128) begin n_bad++; $display("FAIL reset_wiper: got %0d expected 128", wiper); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b expected 0", miso); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_set_ramp();
    logic [15:0] rb;
    bit          found;
    int          cycles;
    spi_xfer(16'h4040, 16, rb);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (busy) begin found = 1'b1; break; end
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL set_busy_rise: got %b expected 1", found); end
    n_cmp++; if (wiper !== 8'd128) begin n_bad++; $display("FAIL set_hold0: got %0d expected 128", wiper); end
    repeat (15) @(posedge clk);
    #1;
    n_cmp++; if (wiper !== 8'd128) begin n_bad++; $display("FAIL set_hold15: got %0d expected 128", wiper); end
    @(posedge clk); #1;
    n_cmp++; if (wiper !== 8'd127) begin n_bad++; $display("FAIL set_first_step: got %0d expected 127", wiper); end
    cycles = 16;
    while (busy && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
    end
    n_cmp++; if (cycles !== 1024) begin n_bad++; $display("FAIL set_ramp_time: got %0d expected 1024", cycles); end
    n_cmp++; if (wiper !== 8'h40) begin n_bad++; $display("FAIL set_final: got %0h expected 40", wiper); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL set_busy_fall: got %b expected 0", busy); end
  endtask

  task automatic test_saturate();
    logic [15:0] rb;
    int          ms;
    spi_xfer(16'h4020, 16, rb);
    wait_settle(1000, ms);
    n_cmp++; if (wiper !== 8'h20) begin n_bad++; $display("FAIL sat_pre: got %0h expected 20", wiper); end
    spi_xfer(16'h80F0, 16, rb);
    wait_settle(5000, ms);
    n_cmp++; if (wiper !== 8'hFF) begin n_bad++; $display("FAIL sat_inc: got %0h expected ff", wiper); end
    n_cmp++; if (ms > 1) begin n_bad++; $display("FAIL sat_inc_step: got %0d expected <=1", ms); end
    spi_xfer(16'h8001, 16, rb);
    wait_settle(100, ms);
    n_cmp++; if (wiper !== 8'hFF || busy !== 1'b0) begin n_bad++; $display("FAIL sat_inc_top: got %0h/%b expected ff/0", wiper, busy); end
    spi_xfer(16'hC0FF, 16, rb);
    wait_settle(5000, ms);
    n_cmp++; if (wiper !== 8'h00) begin n_bad++; $display("FAIL sat_dec: got %0h expected 0", wiper); end
    n_cmp++; if (ms > 1) begin n_bad++; $display("FAIL sat_dec_step: got %0d expected <=1", ms); end
    spi_xfer(16'hC005, 16, rb);
    wait_settle(100, ms);
    n_cmp++; if (wiper !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL sat_dec_floor: got %0h/%b expected 0/0", wiper, busy); end
  endtask

  task automatic test_frame_err();
    logic [15:0] rb;
    spi_xfer(16'h4011, 9, rb);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_short: got %b expected 1", frame_err); end
    n_cmp++; if (wiper !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL ferr_short_target: got %0h/%b expected 0/0", wiper, busy); end
    spi_xfer(16'h0000, 16, rb);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_nop_clear: got %b expected 0", frame_err); end
    spi_xfer(16'h4033, 17, rb);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_long: got %b expected 1", frame_err); end
    n_cmp++; if (wiper !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL ferr_long_target: got %0h/%b expected 0/0", wiper, busy); end
    spi_xfer(16'h405A, 16, rb);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_set_clear: got %b expected 0", frame_err); end
  endtask

  task automatic test_readback();
    logic [15:0] rb;
    int          ms;
    wait_settle(2000, ms);
    n_cmp++; if (wiper !== 8'h5A) begin n_bad++; $display("FAIL rb_pre: got %0h expected 5a", wiper); end
    spi_xfer(16'h0000, 16, rb);
    n_cmp++; if (rb !== 16'h005A) begin n_bad++; $display("FAIL rb_idle: got %04h expected 005a", rb); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL rb_miso_idle: got %b expected 0", miso); end
    spi_xfer(16'h4060, 16, rb);
    repeat (40) @(posedge clk);
    #1;
    spi_xfer(16'h0000, 16, rb);
    n_cmp++; if (rb[15] !== 1'b1) begin n_bad++; $display("FAIL rb_ramp_busy: got %b expected 1", rb[15]); end
    n_cmp++; if (rb[14:8] !== 7'h00) begin n_bad++; $display("FAIL rb_ramp_upper: got %0h expected 0", rb[14:8]); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] word;
    int          ms;
    logic [15:0] rb;
    word = 16'h4020;
    cs_n = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      mosi = word[15 - i];
      #50;
      sclk = 1'b1;
      #50;
      sclk = 1'b0;
    end
    rst  = 1'b1;
    cs_n = 1'b1;
    mosi = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (wiper !== 8'd128) begin n_bad++; $display("FAIL rstmid_wiper: got %0d expected 128", wiper); end
    n_cmp++; if (busy !== 1'b0 || miso !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_miso: got %b/%b expected 0/0", busy, miso); end
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (wiper !== 8'd128 || busy !== 1'b0 || frame_err !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_quiet: got %0d/%b/%b expected 128/0/0", wiper, busy, frame_err);
    end
    spi_xfer(16'h4010, 16, rb);
    wait_settle(3000, ms);
    n_cmp++; if (wiper !== 8'h10) begin n_bad++; $display("FAIL rstmid_set: got %0h expected 10", wiper); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_err: got %b expected 0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_set_ramp();
    test_saturate();
    test_frame_err();
    test_readback();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
